// File: rtl/cpu_timing_pkg.sv
// Shared definitions for the KS10 CPU clock-enable generator.
//   state_e      : sequencer states (IDLE, SHIFT, DONE, STRETCH, HALT)
//   MODE_LEGACY  : shiftMODE value selecting FE-sign terminated shifting
//   MODE_COUNT   : shiftMODE value selecting counted shifting
package cpu_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_DONE    = 3'd2,
        ST_STRETCH = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    localparam logic MODE_LEGACY = 1'b0;
    localparam logic MODE_COUNT  = 1'b1;

endpackage

// File: rtl/timing_downcnt.sv
// Loadable down-counter with hold.
//   clk        : system clock
//   rst        : synchronous active-low reset, clears the count
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one
//   is_one_o   : current count equals 1
// With neither load_i nor dec_i asserted the count holds.
module timing_downcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_one_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/cpu_timing_gen.sv
// KS10 CPU clock-enable generator.
// Produces the microsequencer (clkenCR) and data-path (clkenDP) enables,
// handling maskable wait sources, legacy FE-sign and counted multishift,
// per-microinstruction stretch cycles and single-step halt.
//   clk, rst        : clock, synchronous active-low reset
//   cromMULTISHIFT  : microword multishift field
//   feSIGN          : FE sign, terminates legacy-mode shifts
//   shiftCOUNT      : shift count, sampled at shift start in count mode
//   shiftMODE       : 0 legacy, 1 counted (sampled only in IDLE)
//   waitREQ/waitMASK: wait requests and per-source enables
//   stretch         : dead cycles after each CR-enabled cycle
//   stepEN/stepREQ  : single-step enable and release pulse
//   clkenCR/clkenDP : clock enables
//   busy/halted     : state != IDLE / state == HALT
//   waitACT         : waitREQ & waitMASK
module cpu_timing_gen
    import cpu_timing_pkg::*;
#(
    parameter int NWAIT = 4,
    parameter int CNTW  = 10,
    parameter int STRW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cromMULTISHIFT,
    input  logic             feSIGN,
    input  logic [CNTW-1:0]  shiftCOUNT,
    input  logic             shiftMODE,
    input  logic [NWAIT-1:0] waitREQ,
    input  logic [NWAIT-1:0] waitMASK,
    input  logic [STRW-1:0]  stretch,
    input  logic             stepEN,
    input  logic             stepREQ,
    output logic             clkenCR,
    output logic             clkenDP,
    output logic             busy,
    output logic             halted,
    output logic [NWAIT-1:0] waitACT
);

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   anyWAIT;
    logic   cr_c, dp_c, post_cr;
    logic   sh_load, sh_dec, sh_one;
    logic   st_load, st_dec, st_one;

    assign waitACT = waitREQ & waitMASK;
    assign anyWAIT = |waitACT;

    // Legacy done register keeps running through waits, as before.
    assign done_d = feSIGN & cromMULTISHIFT;

    // The start cycle delivers the first DP enable, so the counter holds
    // the remaining N-1 shifts.
    timing_downcnt #(.W(CNTW)) u_shift_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sh_load),
        .load_val_i (shiftCOUNT - CNTW'(1)),
        .dec_i      (sh_dec),
        .is_one_o   (sh_one)
    );

    timing_downcnt #(.W(STRW)) u_stretch_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (st_load),
        .load_val_i (stretch),
        .dec_i      (st_dec),
        .is_one_o   (st_one)
    );

    always_comb begin
        state_d = state_q;
        cr_c    = 1'b0;
        dp_c    = 1'b0;
        post_cr = 1'b0;
        sh_load = 1'b0;
        sh_dec  = 1'b0;
        st_load = 1'b0;
        st_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (shiftMODE == MODE_LEGACY) begin
                    // Bit-exact with the previous generation.
                    cr_c    = ~((cromMULTISHIFT & feSIGN) | anyWAIT);
                    dp_c    = ~((cromMULTISHIFT & ~feSIGN) | (done_q & cr_c) | anyWAIT);
                    post_cr = cr_c;
                end else if (!anyWAIT) begin
                    if (!cromMULTISHIFT) begin
                        cr_c    = 1'b1;
                        dp_c    = 1'b1;
                        post_cr = 1'b1;
                    end else if (shiftCOUNT == '0) begin
                        cr_c    = 1'b1;
                        post_cr = 1'b1;
                    end else begin
                        dp_c    = 1'b1;
                        sh_load = 1'b1;
                        state_d = (shiftCOUNT > CNTW'(1)) ? ST_SHIFT : ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (!anyWAIT) begin
                    dp_c   = 1'b1;
                    sh_dec = 1'b1;
                    if (sh_one)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!anyWAIT) begin
                    cr_c    = 1'b1;
                    post_cr = 1'b1;
                end
            end
            ST_STRETCH: begin
                if (!anyWAIT) begin
                    st_dec = 1'b1;
                    if (st_one)
                        state_d = stepEN ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: begin
                // Only stepREQ releases; wait is irrelevant with enables low.
                if (stepREQ)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Common sequencing after any CR-enabled cycle.
        if (post_cr) begin
            if (stretch != '0) begin
                state_d = ST_STRETCH;
                st_load = 1'b1;
            end else if (stepEN) begin
                state_d = ST_HALT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign clkenCR = rst & cr_c;
    assign clkenDP = rst & dp_c;
    assign busy    = rst & (state_q != ST_IDLE);
    assign halted  = rst & (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_timing_gen.sv
module tb_cpu_timing_gen;

    localparam int NW = 4;
    localparam int CW = 10;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ms, fe, mode, stepEN, stepREQ;
    logic [CW-1:0] cnt;
    logic [NW-1:0] wreq, wmask, wact;
    logic [SW-1:0] strch;
    logic          cr, dp, busy, halted;

    always #5 clk = ~clk;

    cpu_timing_gen #(.NWAIT(NW), .CNTW(CW), .STRW(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cromMULTISHIFT (ms),
        .feSIGN         (fe),
        .shiftCOUNT     (cnt),
        .shiftMODE      (mode),
        .waitREQ        (wreq),
        .waitMASK       (wmask),
        .stretch        (strch),
        .stepEN         (stepEN),
        .stepREQ        (stepREQ),
        .clkenCR        (cr),
        .clkenDP        (dp),
        .busy           (busy),
        .halted         (halted),
        .waitACT        (wact)
    );

    typedef struct packed {
        logic          cr;
        logic          dp;
        logic          busy;
        logic          halted;
        logic [NW-1:0] wact;
    } obs_t;

    obs_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   dp_seen = 0;
    int   cyc = 0;

    // Reference model: remaining work expressed as plain counts.
    int   m_shifts;   // DP enables still owed in a counted shift
    bit   m_crowed;   // CR-only cycle owed after counted shift
    int   m_dead;     // dead cycles still owed
    bit   m_halt;
    bit   m_done;     // legacy: previous cycle had MULTISHIFT & FE sign

    task automatic model_push();
        obs_t e;
        bit   w, pc;
        e      = '0;
        pc     = 0;
        e.wact = wreq & wmask;
        w      = |e.wact;
        if (!rst) begin
            m_shifts = 0; m_crowed = 0; m_dead = 0; m_halt = 0; m_done = 0;
        end else begin
            e.busy   = m_halt || (m_dead > 0) || (m_shifts > 0) || m_crowed;
            e.halted = m_halt;
            if (m_halt) begin
                if (stepREQ) m_halt = 0;
            end else if (m_dead > 0) begin
                if (!w) begin
                    m_dead--;
                    if (m_dead == 0) m_halt = stepEN;
                end
            end else if (m_shifts > 0) begin
                if (!w) begin e.dp = 1; m_shifts--; end
            end else if (m_crowed) begin
                if (!w) begin e.cr = 1; m_crowed = 0; pc = 1; end
            end else if (!mode) begin
                e.cr = !((ms && fe) || w);
                e.dp = !((ms && !fe) || (m_done && e.cr) || w);
                pc   = e.cr;
            end else if (!w) begin
                if (!ms) begin
                    e.cr = 1; e.dp = 1; pc = 1;
                end else if (cnt == 0) begin
                    e.cr = 1; pc = 1;
                end else begin
                    e.dp = 1; m_shifts = int'(cnt) - 1; m_crowed = 1;
                end
            end
            if (pc) begin
                if (strch != 0) m_dead = int'(strch);
                else if (stepEN) m_halt = 1;
            end
            m_done = fe && ms;
        end
        expq.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_push();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    always @(negedge clk) begin : mon
        obs_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{cr: cr, dp: dp, busy: busy, halted: halted, wact: wact};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle %0d: got cr=%b dp=%b busy=%b halted=%b wact=%b expected cr=%b dp=%b busy=%b halted=%b wact=%b",
                         cyc, a.cr, a.dp, a.busy, a.halted, a.wact, e.cr, e.dp, e.busy, e.halted, e.wact);
            end
            if (a.dp === 1'b1) dp_seen++;
            cyc++;
        end
    end

    task automatic defaults();
        rst = 1; ms = 0; fe = 0; mode = 0; cnt = '0; wreq = '0; wmask = '1;
        strch = '0; stepEN = 0; stepREQ = 0;
    endtask

    // Counted shift: start cycle plus n more covers all DP and the DONE cycle.
    task automatic run_count(input int n, input string nm);
        mode = 1; ms = 1; cnt = CW'(n); dp_seen = 0;
        tick();
        ms = 0;
        tick(n);
        chk_int(nm, dp_seen, n);
    endtask

    initial begin
        m_shifts = 0; m_crowed = 0; m_dead = 0; m_halt = 0; m_done = 0;
        defaults();
        rst = 0;
        @(posedge clk);
        #1;
        tick(2);
        rst = 1;
        tick(2);

        // Legacy: 3 shifts then terminating CR cycle.
        mode = 0; ms = 1; fe = 1;
        tick(3);
        fe = 0;
        tick();
        ms = 0;
        tick(2);
        // Legacy: FE already positive at start gives zero shifts.
        ms = 1; fe = 0;
        tick();
        ms = 0;
        tick();
        // Legacy: done register suppresses DP on the cycle after.
        ms = 1; fe = 1;
        tick();
        ms = 0;
        tick(2);
        fe = 0;

        // Counted shifts, including the full-range count.
        run_count(5, "count5_dp");
        run_count(0, "count0_dp");
        run_count(1, "count1_dp");
        run_count(1023, "count1023_dp");
        ms = 0; tick();

        // Wait masking mid-shift.
        wmask = 4'b0101; wreq = 4'b0010;
        tick(2);
        mode = 1; ms = 1; cnt = CW'(8); dp_seen = 0;
        tick();
        ms = 0;
        tick(2);
        wreq = 4'b0110;
        tick(4);
        wreq = 4'b0010;
        tick(6);
        chk_int("wait_count8_dp", dp_seen, 8);
        wreq = '0; wmask = '1;
        tick();

        // Stretch on normal cycles.
        mode = 0; strch = 3'd3;
        tick(9);
        strch = '0;
        tick(3);

        // Single step with stretch 2.
        stepEN = 1; strch = 3'd2;
        tick(7);
        stepREQ = 1; tick(); stepREQ = 0;
        tick(5);
        stepREQ = 1; tick(); stepREQ = 0;
        tick();                     // CR cycle
        stepREQ = 1; tick(); stepREQ = 0;   // in STRETCH: ignored
        tick(4);
        stepEN = 0;                 // does not release HALT
        tick(3);
        wreq = 4'b0001;
        stepREQ = 1; tick(); stepREQ = 0;   // honoured despite wait
        wreq = '0;
        tick(4);
        strch = '0;

        // Reset mid-shift at remaining count 40.
        mode = 1; ms = 1; cnt = CW'(100);
        tick();
        ms = 0;
        tick(59);
        rst = 0;
        tick();
        rst = 1; ms = 1; mode = 0; fe = 1;
        tick(2);
        defaults();
        tick();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rst     = ($urandom_range(0, 149) != 0);
            ms      = ($urandom_range(0, 3) == 0);
            fe      = 1'($urandom_range(0, 1));
            mode    = 1'($urandom_range(0, 1));
            cnt     = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 40)) : CW'($urandom_range(0, 6));
            wreq    = ($urandom_range(0, 4) == 0) ? NW'($urandom) : '0;
            wmask   = NW'($urandom);
            strch   = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(1, 7)) : '0;
            stepEN  = ($urandom_range(0, 7) == 0);
            stepREQ = ($urandom_range(0, 5) == 0);
            tick();
        end

        chk_int("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
